// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg: shared constants and FSM state type for the instruction-fetch controller
package if_fetch_ctrl_pkg;
   localparam int XLEN_DEF = 32;
   localparam logic [31:0] CPU_RST_ADDR = 32'h0000_0000;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/if_fetch_ctrl_resp_buf.sv
// if_fetch_ctrl_resp_buf: DEPTH-entry synchronous response FIFO with synchronous clear
//   clk, rst_n      clock, async active-low reset
//   clr             drop all entries (wins over push/pop)
//   push, din       write one entry (accepted when not full or popping)
//   pop, dout       read head entry (dout valid while !empty)
//   full, empty     occupancy flags
//   count           current number of entries
module if_fetch_ctrl_resp_buf #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop & ~empty & ~clr;
   assign do_push = push & ~clr & (~full | do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(do_pop);
         wr_ptr <= wr_ptr + AW'(do_push);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer driving a req/gnt/rvalid bus and feeding if_id
//   clk, rst_n                    clock, async active-low reset
//   pipe_stall                    suppress new bus requests
//   pipe_flush                    redirect to RST_ADDR unless a higher target is given
//   trap_flag/trap_addr           redirect, highest priority
//   ex_is_mret_inst/mepc          redirect, middle priority
//   ex_bj_flag/ex_bj_addr         redirect, lowest priority
//   id_allowin                    if_id accepts the presented entry
//   if_ready_go, if_pc, if_inst   presented entry
//   if_exp_flag, if_inst_addr_misal  entry exception / misaligned-target flags
//   ibus_req/addr/gnt             request channel (request held until granted)
//   ibus_rvalid/rdata/err         response channel, one outstanding at most
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter logic [XLEN-1:0] RST_ADDR  = CPU_RST_ADDR,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_stall,
   input  logic            pipe_flush,
   input  logic            trap_flag,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            ex_is_mret_inst,
   input  logic [XLEN-1:0] mepc,
   input  logic            ex_bj_flag,
   input  logic [XLEN-1:0] ex_bj_addr,
   input  logic            id_allowin,
   output logic            if_ready_go,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_inst,
   output logic            if_exp_flag,
   output logic            if_inst_addr_misal,
   output logic            ibus_req,
   output logic [XLEN-1:0] ibus_addr,
   input  logic            ibus_gnt,
   input  logic            ibus_rvalid,
   input  logic [XLEN-1:0] ibus_rdata,
   input  logic            ibus_err
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   fetch_state_e state;
   logic [XLEN-1:0] fetch_pc, req_pc, target;
   logic [2*XLEN+1:0] din, dout;
   logic [CW-1:0] cnt, occ;
   logic kill, park, misal_pend;
   logic redir, rsp, issue, pop, push, full, empty;
   assign redir = pipe_flush | trap_flag | ex_is_mret_inst | ex_bj_flag;
   assign target = trap_flag ? trap_addr : ex_is_mret_inst ? mepc : ex_bj_flag ? ex_bj_addr : RST_ADDR;
   assign rsp = state == WAIT & ibus_rvalid;
   assign if_ready_go = ~empty & ~redir;
   assign pop = if_ready_go & id_allowin;
   // entries that will be buffered after this cycle, including a live in-flight fetch
   assign occ = cnt - CW'(pop) + CW'(state == WAIT & ~kill);
   // a new request may start in IDLE or in the same cycle the previous word returns
   assign issue = rst_n & ~pipe_stall & ~redir & ~park & (occ < CW'(BUF_DEPTH)) & (state == IDLE | rsp);
   assign ibus_req = state == REQ | issue;
   assign ibus_addr = state == REQ ? req_pc : issue ? fetch_pc : '0;
   assign push = ~redir & (misal_pend | rsp & ~kill);
   assign din = misal_pend ? {fetch_pc, XLEN'(INST_NOP), 2'b11}
                           : {req_pc, ibus_err ? XLEN'(INST_NOP) : ibus_rdata, ibus_err, 1'b0};
   assign {if_pc, if_inst, if_exp_flag, if_inst_addr_misal} = empty ? {RST_ADDR, {(XLEN+2){1'b0}}} : dout;
   if_fetch_ctrl_resp_buf #(.WIDTH(2*XLEN+2), .DEPTH(BUF_DEPTH)) u_buf (
      .clk(clk), .rst_n(rst_n), .clr(redir), .push(push), .din(din), .pop(pop),
      .dout(dout), .full(full), .empty(empty), .count(cnt)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         fetch_pc <= RST_ADDR;
         req_pc <= RST_ADDR;
         kill <= 1'b0;
         park <= 1'b0;
         misal_pend <= 1'b0;
      end else begin
         state <= (issue | state == REQ) ? (ibus_gnt ? WAIT : REQ) : (state == WAIT & ~ibus_rvalid) ? WAIT : IDLE;
         // a redirect while a request is pending marks its eventual response stale
         kill <= (state == REQ | state == WAIT & ~ibus_rvalid) & (kill | redir);
         park <= redir ? |target[1:0] : park;
         misal_pend <= redir & |target[1:0];
         if (issue) req_pc <= fetch_pc;
         // a killed request completing does not advance the already-redirected pc
         if (redir) fetch_pc <= target;
         else if (ibus_gnt & (issue | state == REQ & ~kill)) fetch_pc <= fetch_pc + XLEN'(4);
      end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: randomized scoreboard bench for if_fetch_ctrl with a stream-level fetch model
module tb_if_fetch_ctrl;
   import if_fetch_ctrl_pkg::*;
   localparam logic [31:0] RA = 32'h0000_0000;
   logic clk, rst_n, pipe_stall, pipe_flush, trap_flag, ex_is_mret_inst, ex_bj_flag, id_allowin;
   logic [31:0] trap_addr, mepc, ex_bj_addr;
   logic if_ready_go, if_exp_flag, if_inst_addr_misal, ibus_req, ibus_gnt, ibus_rvalid, ibus_err;
   logic [31:0] if_pc, if_inst, ibus_addr, ibus_rdata;

   if_fetch_ctrl #(.XLEN(32), .RST_ADDR(RA), .BUF_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
      .trap_flag(trap_flag), .trap_addr(trap_addr), .ex_is_mret_inst(ex_is_mret_inst), .mepc(mepc),
      .ex_bj_flag(ex_bj_flag), .ex_bj_addr(ex_bj_addr), .id_allowin(id_allowin),
      .if_ready_go(if_ready_go), .if_pc(if_pc), .if_inst(if_inst), .if_exp_flag(if_exp_flag),
      .if_inst_addr_misal(if_inst_addr_misal), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
      .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0, bad = 0, pops = 0, grants = 0, reqs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // reference model: the instruction stream if_id should see, restarted on every redirect
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exp;
      logic        misal;
   } ent_t;
   ent_t exp_q[$];
   logic [31:0] nxt_pc;
   bit parked;
   logic [31:0] err_addr = 32'h0000_0001;
   bit err_rand = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h7A11};
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return (a == err_addr) || (err_rand && a[6:2] == 5'd9);
   endfunction

   task automatic refill();
      ent_t e;
      while (exp_q.size() < 4 && !parked) begin
         e.pc = nxt_pc;
         if (nxt_pc[1:0] != 2'b00) begin
            e.inst = INST_NOP; e.exp = 1'b1; e.misal = 1'b1; parked = 1;
         end else begin
            e.inst = is_err(nxt_pc) ? INST_NOP : mem_word(nxt_pc);
            e.exp = is_err(nxt_pc); e.misal = 1'b0;
            nxt_pc = nxt_pc + 32'd4;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic model_restart(input logic [31:0] t);
      exp_q.delete();
      nxt_pc = t;
      parked = 0;
   endtask

   task automatic redirect(input bit tr, mr, bj, fl, input logic [31:0] ta, ma, ba);
      trap_flag = tr; ex_is_mret_inst = mr; ex_bj_flag = bj; pipe_flush = fl;
      trap_addr = ta; mepc = ma; ex_bj_addr = ba;
      if (tr | mr | bj | fl) model_restart(tr ? ta : mr ? ma : bj ? ba : RA);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input bit tr, mr, bj, fl, input logic [31:0] ta, ma, ba);
      redirect(tr, mr, bj, fl, ta, ma, ba);
      step(1);
      redirect(0, 0, 0, 0, ta, ma, ba);
   endtask

   // monitor: every accepted entry is checked against the head of the expected stream
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (trap_flag | ex_is_mret_inst | ex_bj_flag | pipe_flush) chk("ready_on_redirect", if_ready_go, 0);
            if (if_ready_go && id_allowin) begin
               pops++;
               refill();
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL extra_pop: got pc %h want no entry", if_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("pc", if_pc, e.pc);
                  chk("inst", if_inst, e.inst);
                  chk("exp", if_exp_flag, e.exp);
                  chk("misal", if_inst_addr_misal, e.misal);
               end
            end
         end
      end
   end

   // bus model: random grant, random read latency, protocol checks
   logic [31:0] g_addr, p_addr, hold_addr;
   bit pend = 0, prev_hold = 0;
   int lat = 0, lat_min = 0, lat_max = 0, gnt_pct = 100;
   initial begin
      ibus_gnt = 0; ibus_rvalid = 0; ibus_rdata = 0; ibus_err = 0;
      forever begin
         @(posedge clk);
         if (ibus_gnt) begin
            pend = 1; p_addr = g_addr; lat = $urandom_range(lat_max, lat_min);
         end
         #1;
         ibus_rvalid = 0; ibus_err = 0; ibus_rdata = 0;
         if (pend) begin
            if (lat == 0) begin
               ibus_rvalid = 1; ibus_err = is_err(p_addr);
               ibus_rdata = mem_word(p_addr); pend = 0;
            end else lat--;
         end
         #1;
         ibus_gnt = 0;
         if (rst_n && prev_hold) begin
            chk("req_held", ibus_req, 1);
            chk("addr_stable", ibus_addr, hold_addr);
         end
         if (rst_n && ibus_req) begin
            reqs++;
            chk("req_single_outstanding", pend, 0);
            chk("addr_aligned", ibus_addr[1:0], 0);
            if (!pend && $urandom_range(99, 0) < gnt_pct) begin
               ibus_gnt = 1; g_addr = ibus_addr; grants++;
            end
         end
         prev_hold = rst_n && ibus_req && !ibus_gnt;
         hold_addr = ibus_addr;
      end
   end

   function automatic logic [31:0] rnd_tgt();
      int r;
      r = $urandom_range(7, 0);
      if (r == 0) return {20'h0, 10'($urandom_range(1023, 0)), 2'($urandom_range(3, 1))};
      if (r == 1) return 32'hFFFF_FFF0 + 32'd4 * 32'($urandom_range(3, 0));
      return {22'h0, 8'($urandom_range(255, 0)), 2'b00};
   endfunction

   initial begin
      logic [4:0] seen;
      logic [31:0] ta, ma, ba;
      logic [3:0] k;
      int p0, g0, r0, rc;
      bit found;
      rst_n = 0; id_allowin = 1; pipe_stall = 0;
      redirect(0, 0, 0, 0, 0, 0, 0);
      model_restart(RA);
      step(3);
      @(negedge clk);
      chk("rst_ready_go", if_ready_go, 0);
      chk("rst_pc", if_pc, RA);
      chk("rst_inst", if_inst, 0);
      chk("rst_exp", if_exp_flag, 0);
      chk("rst_misal", if_inst_addr_misal, 0);
      chk("rst_req", ibus_req, 0);
      step(1);
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen[i] = if_ready_go;
      end
      chk("stream_one_per_cycle", seen, 5'b11100);
      step(1);

      lat_min = 2; lat_max = 2;
      pulse(0, 0, 1, 0, 0, 0, 32'h0);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1);
         found = pend && p_addr == 32'h10;
      end
      chk("reach_wait_0x10", found, 1);
      p0 = pops;
      pulse(0, 0, 1, 0, 0, 0, 32'h80);
      step(20);
      chk("bj_progress", pops > p0, 1);

      p0 = pops;
      pulse(1, 0, 1, 0, 32'h100, 0, 32'h200);
      step(20);
      chk("trap_progress", pops > p0, 1);

      lat_min = 0; lat_max = 0;
      p0 = pops;
      pulse(0, 0, 1, 0, 0, 0, 32'h82);
      step(10);
      r0 = reqs;
      step(6);
      chk("misal_no_req", reqs - r0, 0);
      chk("misal_one_entry", pops - p0, 1);

      id_allowin = 0;
      g0 = grants;
      pulse(0, 0, 1, 0, 0, 0, 32'h200);
      step(7);
      chk("hold_grants", grants - g0, 2);
      chk("hold_req_low", ibus_req, 0);
      p0 = pops;
      id_allowin = 1;
      step(10);
      chk("hold_release", pops - p0 >= 3, 1);

      err_addr = 32'h40;
      p0 = pops;
      pulse(0, 0, 1, 0, 0, 0, 32'h40);
      step(10);
      chk("err_progress", pops > p0, 1);

      err_addr = 32'h1;
      lat_min = 6; lat_max = 6;
      pulse(0, 0, 1, 0, 0, 0, 32'h300);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         found = pend && p_addr == 32'h300;
      end
      chk("reach_wait_0x300", found, 1);
      pipe_stall = 1; rst_n = 0;
      model_restart(RA);
      @(negedge clk);
      chk("midrst_ready_go", if_ready_go, 0);
      chk("midrst_req", ibus_req, 0);
      chk("midrst_pc", if_pc, RA);
      chk("midrst_inst", if_inst, 0);
      step(2);
      rst_n = 1;
      rc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rc += int'(if_ready_go);
      end
      step(1);
      chk("stale_rvalid_dropped", rc, 0);
      chk("stale_rvalid_seen", pend, 0);
      lat_min = 0; lat_max = 1;
      pipe_stall = 0;
      p0 = pops;
      step(15);
      chk("post_reset_progress", pops > p0, 1);

      gnt_pct = 70; lat_min = 0; lat_max = 2; err_rand = 1;
      pulse(0, 0, 0, 1, 32'h100, 32'h180, 32'h200);
      for (int i = 0; i < 3000; i++) begin
         pipe_stall = ($urandom_range(4, 0) == 0);
         id_allowin = ($urandom_range(3, 0) != 0);
         if ($urandom_range(29, 0) == 0) begin
            ta = rnd_tgt(); ma = rnd_tgt(); ba = rnd_tgt();
            k = 4'($urandom_range(15, 1));
            redirect(k[0], k[1], k[2], k[3], ta, ma, ba);
         end else redirect(0, 0, 0, 0, trap_addr, mepc, ex_bj_addr);
         step(1);
      end
      redirect(0, 0, 0, 0, 0, 0, 0);
      pipe_stall = 0; id_allowin = 1;
      step(30);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
